// File: rtl/dot_job_sequencer.sv
// dot_job_sequencer: initiator side of the dot-product engine handshake.
// Takes a job command (two operand base addresses), fetches both N-byte
// vectors from operand SRAM, presents them on dot_a/dot_b, pulses dot_start,
// waits for dot_done (or gives up after TIMEOUT cycles) and hands the 16-bit
// result to a valid/ready output register. One job is in flight at a time.
module dot_job_sequencer #(
  parameter int N       = 32,
  parameter int AW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_a_base,
  input  logic [AW-1:0]   cmd_b_base,
  output logic            mem_rd_en,
  output logic [AW-1:0]   mem_addr,
  input  logic [7:0]      mem_rdata,
  output logic [N*8-1:0]  dot_a,
  output logic [N*8-1:0]  dot_b,
  output logic            dot_start,
  input  logic [15:0]     dot_c,
  input  logic            dot_done,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [15:0]     res_data,
  output logic            busy,
  output logic            err_timeout
);

  // Fetch index covers both vectors: 0..N-1 is A, N..2N-1 is B.
  localparam int KW = $clog2(2 * N);
  // Wait counter only has to reach TIMEOUT-1.
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(2 * N - 1);
  localparam logic [KW-1:0] K_B0   = KW'(N);
  localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_PUSH  = 3'd5;

  logic [2:0]    state;
  logic [AW-1:0] a_base_q;
  logic [AW-1:0] b_base_q;
  logic [KW-1:0] k;
  logic          cap_valid;
  logic [KW-1:0] cap_k;
  logic [WW-1:0] wait_cnt;
  logic [15:0]   result_q;
  logic          push_fire;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign mem_rd_en = (state == S_FETCH);
  assign dot_start = (state == S_START);
  assign push_fire = (state == S_PUSH) && (!res_valid || res_ready);

  // Read address for the current fetch index; forced to zero outside FETCH.
  always_comb begin
    mem_addr = '0;
    if (state == S_FETCH) begin
      if (k < K_B0) begin
        mem_addr = a_base_q + AW'(k);
      end else begin
        mem_addr = b_base_q + AW'(k - K_B0);
      end
    end
  end

  // Job sequencing: command capture, fetch walk, start, wait/timeout, push.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      a_base_q    <= '0;
      b_base_q    <= '0;
      k           <= '0;
      wait_cnt    <= '0;
      result_q    <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            a_base_q <= cmd_a_base;
            b_base_q <= cmd_b_base;
            k        <= '0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (k == K_LAST) begin
            state <= S_DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DRAIN: begin
          state <= S_START;
        end
        S_START: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (dot_done) begin
            result_q <= dot_c;
            state    <= S_PUSH;
          end else if (wait_cnt == W_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_PUSH: begin
          if (push_fire) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // SRAM data lags the strobe by one cycle, so remember which index is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_k     <= '0;
    end else begin
      cap_valid <= (state == S_FETCH);
      cap_k     <= k;
    end
  end

  // Drop each returned byte into its slot of the A or B operand bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      dot_a <= '0;
      dot_b <= '0;
    end else if (cap_valid) begin
      for (int i = 0; i < N; i++) begin
        if (cap_k == KW'(i)) begin
          dot_a[8*i +: 8] <= mem_rdata;
        end
        if (cap_k == KW'(N + i)) begin
          dot_b[8*i +: 8] <= mem_rdata;
        end
      end
    end
  end

  // Output register: a reload wins over a same-cycle handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (push_fire) begin
      res_valid <= 1'b1;
      res_data  <= result_q;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
